// File: rtl/dart_pkg.sv
// Shared types and constants for the dart thrower stimulus engine.
package dart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWarmup,
    StThrow,
    StWaitDone,
    StGap,
    StFinish
  } dart_state_e;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
  localparam logic [1:0] WINNER_ERR  = 2'b11;

  localparam int unsigned BOARD_DIM     = 10;
  localparam int unsigned WARMUP_CYCLES = 2;

  // Fold a 4-bit LFSR nibble onto the 0..9 board range.
  function automatic logic [3:0] to_coord(input logic [3:0] v);
    return (v >= 4'(BOARD_DIM)) ? v - 4'(BOARD_DIM) : v;
  endfunction

endpackage

// File: rtl/dart_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), shifting left with feedback into bit 0.
module dart_lfsr8 (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  // Next value: shift left, XOR of taps 8,6,5,4 enters at bit 0.
  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // State register; reset reloads the (nonzero) seed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/dart_thrower.sv
// Player-side stimulus engine: alternates players, throws pseudo-random darts and
// waits for the scoring machine's done handshake until the game ends.
module dart_thrower #(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned MAX_THROWS = 1000,
  parameter int unsigned CNT_W      = 10,
  parameter logic [7:0]  SEED_X     = 8'hA5,
  parameter logic [7:0]  SEED_Y     = 8'h3C
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             player_1_done_i,
  input  logic             player_2_done_i,
  input  logic             game_set_i,
  input  logic             player_1_win_i,
  input  logic             player_2_win_i,
  output logic             dart_come_o,
  output logic [3:0]       dart_position_x_o,
  output logic [3:0]       dart_position_y_o,
  output logic             current_player_o,
  output logic [CNT_W-1:0] throw_count_o,
  output logic             game_over_o,
  output logic [1:0]       winner_o
);

  import dart_pkg::*;

  localparam int unsigned TimerW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  dart_state_e       state_q, state_d;
  logic [1:0]        warm_q, warm_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [TimerW-1:0] timer_inc;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        x_q, x_d;
  logic [3:0]        y_q, y_d;
  logic              come_q, come_d;
  logic              player_q, player_d;
  logic              over_q, over_d;
  logic [1:0]        winner_q, winner_d;

  logic       lfsr_step;
  logic [7:0] lfsr_x;
  logic [7:0] lfsr_y;
  logic       launch;
  logic       new_game;
  logic       done_match;
  logic       done_other;
  logic       done_both;
  logic [1:0] win_claim;

  dart_lfsr8 u_lfsr_x (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED_X),
    .step  (lfsr_step),
    .q     (lfsr_x)
  );

  dart_lfsr8 u_lfsr_y (
    .clk   (clk),
    .reset (reset),
    .seed  (SEED_Y),
    .step  (lfsr_step),
    .q     (lfsr_y)
  );

  assign done_match = player_q ? player_2_done_i : player_1_done_i;
  assign done_other = player_q ? player_1_done_i : player_2_done_i;
  assign done_both  = player_1_done_i & player_2_done_i;
  assign win_claim  = {player_2_win_i, player_1_win_i};
  assign timer_inc  = timer_q + 1'b1;

  // Next-state and registered-output logic for the turn sequencer.
  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    timer_d   = timer_q;
    count_d   = count_q;
    x_d       = x_q;
    y_d       = y_q;
    come_d    = 1'b0;
    player_d  = player_q;
    over_d    = over_q;
    winner_d  = winner_q;
    lfsr_step = 1'b0;
    launch    = 1'b0;
    new_game  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) new_game = 1'b1;
      end
      StWarmup: begin
        if (warm_q == 2'(WARMUP_CYCLES - 1)) begin
          launch = 1'b1;
        end else begin
          warm_d = warm_q + 1'b1;
        end
      end
      StThrow: begin
        state_d = StWaitDone;
        timer_d = '0;
      end
      StWaitDone: begin
        if (done_both || done_other) begin
          winner_d = WINNER_ERR;
          over_d   = 1'b1;
          state_d  = StFinish;
        end else if (done_match) begin
          if (game_set_i) begin
            // A game_set naming nobody or both players is treated as a protocol error.
            winner_d = (win_claim == 2'b00 || win_claim == 2'b11) ? WINNER_ERR : win_claim;
            over_d   = 1'b1;
            state_d  = StFinish;
          end else if (count_q == CNT_W'(MAX_THROWS)) begin
            winner_d = WINNER_NONE;
            over_d   = 1'b1;
            state_d  = StFinish;
          end else begin
            player_d = ~player_q;
            state_d  = StGap;
          end
        end else if (timer_inc == TimerW'(TIMEOUT - 1)) begin
          // Lands in FINISH exactly TIMEOUT cycles after the dart pulse.
          winner_d = WINNER_ERR;
          over_d   = 1'b1;
          state_d  = StFinish;
        end else begin
          timer_d = timer_inc;
        end
      end
      StGap: begin
        launch = 1'b1;
      end
      StFinish: begin
        if (start_i) new_game = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (new_game) begin
      state_d  = StWarmup;
      warm_d   = '0;
      count_d  = '0;
      winner_d = WINNER_NONE;
      player_d = 1'b0;
      over_d   = 1'b0;
    end

    // Position and pulse are registered on entry to THROW so they are valid during it.
    if (launch) begin
      state_d   = StThrow;
      come_d    = 1'b1;
      x_d       = to_coord(lfsr_x[3:0]);
      y_d       = to_coord(lfsr_y[3:0]);
      lfsr_step = 1'b1;
      count_d   = count_q + 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      warm_q   <= '0;
      timer_q  <= '0;
      count_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      come_q   <= 1'b0;
      player_q <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= WINNER_NONE;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      x_q      <= x_d;
      y_q      <= y_d;
      come_q   <= come_d;
      player_q <= player_d;
      over_q   <= over_d;
      winner_q <= winner_d;
    end
  end

  assign dart_come_o       = come_q;
  assign dart_position_x_o = x_q;
  assign dart_position_y_o = y_q;
  assign current_player_o  = player_q;
  assign throw_count_o     = count_q;
  assign game_over_o       = over_q;
  assign winner_o          = winner_q;

endmodule

// File: tb/tb_dart_thrower.sv
// Scoreboard bench for dart_thrower: a responder plays the scoring machine, a model predicts
// every dart, and a monitor compares each pulse plus position stability.
module tb_dart_thrower;

  localparam int unsigned TIMEOUT    = 16;
  localparam int unsigned MAX_THROWS = 1000;
  localparam int unsigned LIM_THROWS = 4;
  localparam logic [7:0]  SEED_X     = 8'hA5;
  localparam logic [7:0]  SEED_Y     = 8'h3C;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, p1_done, p2_done, game_set, p1_win, p2_win;
  logic       dart_come, cur_player, game_over;
  logic [3:0] pos_x, pos_y;
  logic [9:0] throw_count;
  logic [1:0] winner;

  logic       l_start, l_p1_done, l_p2_done;
  logic       l_come, l_player, l_over;
  logic [3:0] l_x, l_y;
  logic [9:0] l_count;
  logic [1:0] l_winner;

  always #5 clk = ~clk;

  dart_thrower #(
    .TIMEOUT    (TIMEOUT),
    .MAX_THROWS (MAX_THROWS),
    .CNT_W      (10),
    .SEED_X     (SEED_X),
    .SEED_Y     (SEED_Y)
  ) dut (
    .clk               (clk),
    .reset             (reset_n),
    .start_i           (start),
    .player_1_done_i   (p1_done),
    .player_2_done_i   (p2_done),
    .game_set_i        (game_set),
    .player_1_win_i    (p1_win),
    .player_2_win_i    (p2_win),
    .dart_come_o       (dart_come),
    .dart_position_x_o (pos_x),
    .dart_position_y_o (pos_y),
    .current_player_o  (cur_player),
    .throw_count_o     (throw_count),
    .game_over_o       (game_over),
    .winner_o          (winner)
  );

  dart_thrower #(
    .TIMEOUT    (TIMEOUT),
    .MAX_THROWS (LIM_THROWS),
    .CNT_W      (10),
    .SEED_X     (SEED_X),
    .SEED_Y     (SEED_Y)
  ) dut_lim (
    .clk               (clk),
    .reset             (reset_n),
    .start_i           (l_start),
    .player_1_done_i   (l_p1_done),
    .player_2_done_i   (l_p2_done),
    .game_set_i        (1'b0),
    .player_1_win_i    (1'b0),
    .player_2_win_i    (1'b0),
    .dart_come_o       (l_come),
    .dart_position_x_o (l_x),
    .dart_position_y_o (l_y),
    .current_player_o  (l_player),
    .throw_count_o     (l_count),
    .game_over_o       (l_over),
    .winner_o          (l_winner)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference model: expected dart per pulse.
  typedef struct {
    int x;
    int y;
    int pl;
    int cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_lx, m_ly;
  int         m_player, m_count;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic fb;
    fb = ^(s & 8'hB8);
    return 8'((s << 1) | {7'd0, fb});
  endfunction

  function automatic int coord(input logic [7:0] s);
    return int'(s % 16) % 10;
  endfunction

  task automatic push_next();
    exp_t e;
    m_count++;
    e.x   = coord(m_lx);
    e.y   = coord(m_ly);
    e.pl  = m_player;
    e.cnt = m_count;
    exp_q.push_back(e);
    m_lx = lfsr_next(m_lx);
    m_ly = lfsr_next(m_ly);
  endtask

  // Monitor: pops an expectation on every pulse and checks hold/stability rules.
  initial begin
    bit   prev;
    bit   hold;
    int   hx, hy;
    exp_t e;
    prev = 1'b0;
    hold = 1'b0;
    hx   = 0;
    hy   = 0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        hold = 1'b0;
        prev = 1'b0;
        continue;
      end
      if (dart_come === 1'b1) begin
        check("come_back_to_back", 32'(prev), 0);
        check("x_in_range", 32'(pos_x > 4'd9), 0);
        check("y_in_range", 32'(pos_y > 4'd9), 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pulse_expected: got a dart pulse, required none pending");
        end else begin
          e = exp_q.pop_front();
          check("pulse_x", pos_x, e.x);
          check("pulse_y", pos_y, e.y);
          check("pulse_player", cur_player, e.pl);
          check("pulse_count", throw_count, e.cnt);
        end
        hold = 1'b1;
        hx   = int'(pos_x);
        hy   = int'(pos_y);
      end else if (hold) begin
        check("x_stable", pos_x, hx);
        check("y_stable", pos_y, hy);
        if (p1_done || p2_done) hold = 1'b0;
      end
      prev = dart_come;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game();
    start    = 1'b1;
    m_player = 0;
    m_count  = 0;
    push_next();
  endtask

  // Waits (bounded) for the next pulse, releasing any one-cycle inputs after the first edge.
  task automatic wait_pulse(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while (n < 20) begin
      tick();
      n++;
      start    = 1'b0;
      p1_done  = 1'b0;
      p2_done  = 1'b0;
      game_set = 1'b0;
      p1_win   = 1'b0;
      p2_win   = 1'b0;
      if (dart_come === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL pulse_wait: got no dart pulse in 20 cycles, required one");
    end
  endtask

  // Plays the scoring machine until the game ends; scored=1 deducts 3 points per dart from 501.
  task automatic run_game(input bit scored);
    int n;
    bit ok;
    bit first;
    bit gs;
    bit fin;
    int s1, s2;
    s1    = 501;
    s2    = 501;
    first = 1'b1;
    start_game();
    forever begin
      wait_pulse(n, ok);
      if (!ok) return;
      if (first) check("start_latency", n, 3);
      else check("done_latency", n, 2);
      first = 1'b0;
      repeat ($urandom_range(4, 0) + 1) tick();
      gs = 1'b0;
      if (scored) begin
        if (m_player == 0) s1 -= 3;
        else s2 -= 3;
        gs = (s1 == 0) || (s2 == 0);
      end
      fin = gs || (m_count == int'(MAX_THROWS));
      if (m_player == 0) p1_done = 1'b1;
      else p2_done = 1'b1;
      game_set = gs;
      p1_win   = scored && (s1 == 0);
      p2_win   = scored && (s2 == 0);
      if (!fin) begin
        m_player ^= 1;
        push_next();
      end else begin
        tick();
        p1_done  = 1'b0;
        p2_done  = 1'b0;
        game_set = 1'b0;
        p1_win   = 1'b0;
        p2_win   = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    int n;
    bit ok;
    int pl;
    start     = 1'b0;
    p1_done   = 1'b0;
    p2_done   = 1'b0;
    game_set  = 1'b0;
    p1_win    = 1'b0;
    p2_win    = 1'b0;
    l_start   = 1'b0;
    l_p1_done = 1'b0;
    l_p2_done = 1'b0;
    m_lx      = SEED_X;
    m_ly      = SEED_Y;
    m_player  = 0;
    m_count   = 0;
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) tick();
    check("reset_come", dart_come, 0);
    check("reset_over", game_over, 0);
    check("reset_winner", winner, 0);
    check("reset_count", throw_count, 0);
    check("reset_lim_over", l_over, 0);
    reset_n = 1'b1;
    tick();

    // Reset in the middle of WAIT_DONE.
    start_game();
    wait_pulse(n, ok);
    check("first_latency", n, 3);
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("midrst_come", dart_come, 0);
    check("midrst_x", pos_x, 0);
    check("midrst_y", pos_y, 0);
    check("midrst_player", cur_player, 0);
    check("midrst_count", throw_count, 0);
    check("midrst_over", game_over, 0);
    check("midrst_winner", winner, 0);
    tick();
    tick();
    reset_n = 1'b1;
    m_lx    = SEED_X;
    m_ly    = SEED_Y;
    tick();
    check("midrst_idle_no_pulse", dart_come, 0);

    // Done timeout; the first pulse also proves the LFSRs were reseeded.
    start_game();
    wait_pulse(n, ok);
    check("timeout_start_latency", n, 3);
    repeat (15) tick();
    check("timeout_not_yet_over", game_over, 0);
    check("timeout_not_yet_winner", winner, 0);
    tick();
    check("timeout_over", game_over, 1);
    check("timeout_winner", winner, 3);

    // Protocol error: player 2 reports while player 1 is up.
    start_game();
    wait_pulse(n, ok);
    tick();
    p2_done = 1'b1;
    tick();
    p2_done = 1'b0;
    check("proto_over", game_over, 1);
    check("proto_winner", winner, 3);
    check("proto_count", throw_count, 1);
    tick();
    check("proto_frozen_count", throw_count, 1);

    // Full game, 3 points per dart from 501: player 1 wins on throw 333.
    run_game(1'b1);
    check("game_over", game_over, 1);
    check("game_winner", winner, 1);
    check("game_count", throw_count, 333);
    check("game_queue_empty", exp_q.size(), 0);

    // 1000 unscored throws: range/stability monitored, ends at the throw limit.
    run_game(1'b0);
    check("range_over", game_over, 1);
    check("range_winner", winner, 0);
    check("range_count", throw_count, MAX_THROWS);

    // Throw limit of 4 on the second instance.
    l_start = 1'b1;
    tick();
    l_start = 1'b0;
    pl      = 0;
    for (int t = 0; t < int'(LIM_THROWS); t++) begin
      n = 0;
      while (l_come !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      if (l_come !== 1'b1) begin
        checks++;
        failures++;
        $display("FAIL lim_pulse_wait: got no pulse, required throw %0d", t + 1);
        break;
      end
      tick();
      if (pl == 0) l_p1_done = 1'b1;
      else l_p2_done = 1'b1;
      tick();
      l_p1_done = 1'b0;
      l_p2_done = 1'b0;
      pl ^= 1;
    end
    check("lim_over", l_over, 1);
    check("lim_winner", l_winner, 0);
    check("lim_count", l_count, LIM_THROWS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
